// File: rtl/y_fetch_pkg.sv
// Shared types and constants for the y_fetch PC / instruction-fetch stage.
package y_fetch_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StReq,
    StWait,
    StValid
  } fetch_state_e;

  localparam int unsigned INSN_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/y_pc_reg.sv
// Program-counter register: async reset, load (priority) and sequential increment.
module y_pc_reg
  import y_fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4
);

  logic [WIDTH-1:0] pc_q;

  // Wraps naturally at 2^WIDTH.
  assign pc_plus4 = pc_q + WIDTH'(INSN_BYTES);
  assign pc       = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= load_val;
    end else if (inc) begin
      pc_q <= pc_plus4;
    end
  end

endmodule

// File: rtl/y_fetch_pc.sv
// PC and instruction-fetch stage: imem req/ack handshake and valid/ready to decode.
// Optional Y_FETCH_MISALIGN_TRAP_EN: misaligned redirects set a sticky error and park the FSM.
module y_fetch_pc
  import y_fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] next_pc_in,
  input  logic             redirect,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4
`ifdef Y_FETCH_MISALIGN_TRAP_EN
  ,
  output logic             misalign_err
`endif
);

  fetch_state_e     state_q, state_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [WIDTH-1:0] inst_q, inst_d;
  logic             pc_load, pc_inc;
  logic [WIDTH-1:0] pc_load_val, pc;
  logic [WIDTH-1:0] tgt;
  logic             bad_tgt, trap, parked;

  assign tgt  = {next_pc_in[WIDTH-1:2], 2'b00};
  assign trap = redirect && bad_tgt && (state_q != StBoot);

`ifdef Y_FETCH_MISALIGN_TRAP_EN
  logic err_q;

  assign bad_tgt      = |next_pc_in[1:0];
  assign parked       = err_q;
  assign misalign_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (trap) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^next_pc_in[1:0];
  assign bad_tgt         = 1'b0;
  assign parked          = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;
    inst_d      = inst_q;
    pc_load     = 1'b0;
    pc_load_val = tgt;
    pc_inc      = 1'b0;

    unique case (state_q)
      StBoot: begin
        if (!parked) state_d = StReq;
      end
      StReq: begin
        state_d = StWait;
        if (redirect) begin
          pend_d    = 1'b1;
          pend_pc_d = tgt;
        end
      end
      StWait: begin
        if (imem_ack) begin
          if (redirect || pend_q) begin
            // Fetched word is stale: drop it and refetch from the newest target.
            pc_load     = 1'b1;
            pc_load_val = redirect ? tgt : pend_pc_q;
            pend_d      = 1'b0;
            state_d     = StReq;
          end else begin
            inst_d  = imem_rdata;
            state_d = StValid;
          end
        end else if (redirect) begin
          pend_d    = 1'b1;
          pend_pc_d = tgt;
        end
      end
      StValid: begin
        if (redirect) begin
          pc_load = 1'b1;
          state_d = StReq;
        end else if (inst_ready) begin
          pc_inc  = 1'b1;
          state_d = StReq;
        end
      end
      default: state_d = StBoot;
    endcase

    if (trap) begin
      state_d = StBoot;
      pend_d  = 1'b0;
      inst_d  = inst_q;
      pc_load = 1'b0;
      pc_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StBoot;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      inst_q    <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      inst_q    <= inst_d;
    end
  end

  y_pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  assign imem_req   = (state_q == StReq) || (state_q == StWait);
  assign imem_addr  = pc;
  assign pc_out     = pc;
  assign inst_valid = (state_q == StValid);
  assign inst_out   = inst_q;

endmodule

// File: tb/tb_y_fetch_pc.sv
// Scoreboard bench for y_fetch_pc: memory model returns ~addr, monitor checks decode handshakes.
module tb_y_fetch_pc;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic        imem_ack = 1'b0;
  logic        inst_ready = 1'b0;
  logic [31:0] next_pc_in = '0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst_out, pc_out, pc_plus4;
`ifdef Y_FETCH_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] req_log[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          lat = 1;
  int          mcnt = 0;
  int          hits108 = 0;

  always #5 clk = ~clk;

  y_fetch_pc #(
    .WIDTH    (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .next_pc_in   (next_pc_in),
    .redirect     (redirect),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_out     (inst_out),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4)
`ifdef Y_FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (inst_valid) break;
    end
    check({name, "_valid"}, 32'(inst_valid), 32'd1);
  endtask

  // Waits for a request at target; any decode-valid on the way means a stale word leaked.
  task automatic wait_addr(input string name, input logic [31:0] target);
    bit seen_valid = 1'b0;
    bit hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      if (inst_valid) seen_valid = 1'b1;
      if (imem_req && imem_addr == target) hit = 1'b1;
    end
    check({name, "_nodata"}, 32'(seen_valid), 32'd0);
    check({name, "_addr"}, 32'(hit), 32'd1);
  endtask

  // Memory model: acks on the lat-th WAIT cycle with rdata = ~addr.
  always @(negedge clk) begin
    if (!rst_n) begin
      mcnt     = 0;
      imem_ack = 1'b0;
    end else begin
      imem_ack = 1'b0;
      if (imem_req) begin
        mcnt++;
        if (mcnt == 1) req_log.push_back(imem_addr);
        if (mcnt >= lat + 1) begin
          imem_ack   = 1'b1;
          imem_rdata = ~imem_addr;
          mcnt       = 0;
        end
      end
    end
  end

  // Monitor: every accepted decode handshake must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && inst_valid && inst_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got pc 0x%08h inst 0x%08h, want none", pc_out, inst_out);
        end else begin
          e = sb.pop_front();
          check("sb_pc", pc_out, e.pc);
          check("sb_inst", inst_out, e.inst);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_pc", pc_out, RST_PC);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_plus4", pc_plus4, 32'h0000_0104);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst_out, 32'd0);
`ifdef Y_FETCH_MISALIGN_TRAP_EN
    check("rst_err", 32'(misalign_err), 32'd0);
`endif

    // Basic fetch with decode always ready.
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    sb.push_back('{pc: 32'h0000_0100, inst: 32'hFFFF_FEFF});
    @(negedge clk);
    check("a_first_req", 32'(imem_req), 32'd1);
    check("a_first_addr", imem_addr, 32'h0000_0100);
    @(negedge clk);
    @(negedge clk);
    check("a_latency_valid", 32'(inst_valid), 32'd1);
    check("a_plus4", pc_plus4, 32'h0000_0104);
    @(negedge clk);
    check("a_addr2", imem_addr, 32'h0000_0104);
    check("a_req2", 32'(imem_req), 32'd1);
    check("a_plus4_2", pc_plus4, 32'h0000_0108);
    inst_ready = 1'b0;

    // Decode backpressure on 0x104.
    wait_valid("b");
    for (int i = 0; i < 5; i++) begin
      check("b_stall_valid", 32'(inst_valid), 32'd1);
      check("b_stall_inst", inst_out, 32'hFFFF_FEFB);
      check("b_stall_pc", pc_out, 32'h0000_0104);
      check("b_stall_req", 32'(imem_req), 32'd0);
      @(negedge clk);
    end

    // Redirect in VALID together with ready: instruction consumed, PC takes target.
    sb.push_back('{pc: 32'h0000_0104, inst: 32'hFFFF_FEFB});
    redirect   = 1'b1;
    next_pc_in = 32'h0000_0200;
    inst_ready = 1'b1;
    lat        = 4;
    @(negedge clk);
    redirect   = 1'b0;
    inst_ready = 1'b0;
    check("c_valid_drop", 32'(inst_valid), 32'd0);
    check("c_addr", imem_addr, 32'h0000_0200);
    check("c_req", 32'(imem_req), 32'd1);
    foreach (req_log[i]) if (req_log[i] == 32'h0000_0108) hits108++;
    check("c_no_0x108", 32'(hits108), 32'd0);

    // Redirect during slow fetch: ack arrives 3 cycles after the redirect.
    @(negedge clk);
    redirect   = 1'b1;
    next_pc_in = 32'h0000_0300;
    @(negedge clk);
    redirect = 1'b0;
    wait_addr("d", 32'h0000_0300);
    lat = 1;
    sb.push_back('{pc: 32'h0000_0300, inst: 32'hFFFF_FCFF});
    inst_ready = 1'b1;
    wait_valid("d");

    // Redirect in REQ to the top word, then wrap-around.
    @(negedge clk);
    check("e_addr_304", imem_addr, 32'h0000_0304);
    redirect   = 1'b1;
    next_pc_in = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    wait_addr("e", 32'hFFFF_FFFC);
    check("e_wrap_plus4", pc_plus4, 32'h0000_0000);
    sb.push_back('{pc: 32'hFFFF_FFFC, inst: 32'h0000_0003});
    wait_valid("e");
    @(negedge clk);
    check("e_wrap_addr", imem_addr, 32'h0000_0000);
    check("e_wrap_req", 32'(imem_req), 32'd1);

    // Asynchronous reset in the middle of WAIT.
    lat        = 10;
    inst_ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("g_req", 32'(imem_req), 32'd0);
    check("g_pc", pc_out, RST_PC);
    check("g_addr", imem_addr, RST_PC);
    check("g_valid", 32'(inst_valid), 32'd0);
    check("g_inst", inst_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat   = 1;
    @(negedge clk);
    check("g_req2", 32'(imem_req), 32'd1);
    check("g_addr2", imem_addr, RST_PC);

    // Misaligned redirect in VALID.
    wait_valid("f");
    check("f_inst", inst_out, 32'hFFFF_FEFF);
    redirect   = 1'b1;
    next_pc_in = 32'h0000_0202;
    @(negedge clk);
    redirect = 1'b0;
    check("f_valid", 32'(inst_valid), 32'd0);
`ifdef Y_FETCH_MISALIGN_TRAP_EN
    check("f_err", 32'(misalign_err), 32'd1);
    check("f_req", 32'(imem_req), 32'd0);
    repeat (3) @(negedge clk);
    check("f_park_req", 32'(imem_req), 32'd0);
    check("f_err_sticky", 32'(misalign_err), 32'd1);
    check("f_park_pc", pc_out, RST_PC);
`else
    check("f_addr", imem_addr, 32'h0000_0200);
    check("f_req", 32'(imem_req), 32'd1);
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
